// File: rtl/regfile_operand_fetch_if.sv
// ----------------------------------------------------------------------------
// RegfileOperandFetchIf
//
// Purpose:
//    Bundles every non-clock/reset signal of regfile_operand_fetch: the
//    decode-side valid/ready handshake, the execute-side operand handshake,
//    the writeback bus, both register file read ports, the register file
//    write port and the stall counter.
//
// Modports:
//    slave  - the operand fetch block (receives instructions, writeback and
//             register file read data; drives everything else)
//    master - the surrounding pipeline/register file (mirror image)
//
// Signal summary:
//    in_valid/in_ready, in_rs0, in_rs1, in_rd, in_rd_en  decode side
//    out_valid/out_ready, out_op0, out_op1, out_rd,
//    out_rd_en                                         execute side
//    wb_valid, wb_addr, wb_data                        writeback
//    rf_ra0, rf_ra1, rf_out0, rf_out1                  register file reads
//    rf_we, rf_wa, rf_wd                               register file write
//    stall_cnt                                         hazard stall cycles
// ----------------------------------------------------------------------------
interface regfile_operand_fetch_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_rs0;
   logic [ADDR_W-1:0] in_rs1;
   logic [ADDR_W-1:0] in_rd;
   logic              in_rd_en;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_op0;
   logic [DATA_W-1:0] out_op1;
   logic [ADDR_W-1:0] out_rd;
   logic              out_rd_en;

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic [ADDR_W-1:0] rf_ra0;
   logic [ADDR_W-1:0] rf_ra1;
   logic [DATA_W-1:0] rf_out0;
   logic [DATA_W-1:0] rf_out1;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_wa;
   logic [DATA_W-1:0] rf_wd;

   logic [CNT_W-1:0]  stall_cnt;

   // View seen by the operand fetch block itself.
   modport slave (
      input  in_valid, in_rs0, in_rs1, in_rd, in_rd_en,
      input  out_ready,
      input  wb_valid, wb_addr, wb_data,
      input  rf_out0, rf_out1,
      output in_ready,
      output out_valid, out_op0, out_op1, out_rd, out_rd_en,
      output rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd,
      output stall_cnt
   );

   // View seen by the decode/execute/writeback stages and the register file.
   modport master (
      output in_valid, in_rs0, in_rs1, in_rd, in_rd_en,
      output out_ready,
      output wb_valid, wb_addr, wb_data,
      output rf_out0, rf_out1,
      input  in_ready,
      input  out_valid, out_op0, out_op1, out_rd, out_rd_en,
      input  rf_ra0, rf_ra1, rf_we, rf_wa, rf_wd,
      input  stall_cnt
   );

endinterface

// File: rtl/regfile_operand_fetch.sv
// ----------------------------------------------------------------------------
// regfile_operand_fetch
//
// Purpose:
//    Operand fetch controller in front of a 2**ADDR_W x DATA_W register file.
//    Accepts decoded instruction fields, blocks on RAW/WAW hazards using a
//    per-register pending scoreboard, bypasses same-cycle writeback data, and
//    presents both operands registered (1-cycle latency) to execute. It also
//    owns the register file write port and keeps register 0 hardwired to 0.
//
// Ports:
//    clock  - system clock, rising edge
//    reset  - asynchronous, active-low reset
//    bus    - regfile_operand_fetch_if.slave (decode, execute, writeback,
//             register file read/write ports, stall counter)
//
// Configuration:
//    OPFETCH_STALL_CNT_EN - when defined, bus.stall_cnt is a saturating
//                           count of cycles in which a valid instruction was
//                           held back by a hazard; when undefined the counter
//                           is not built and bus.stall_cnt reads 0.
// ----------------------------------------------------------------------------
module regfile_operand_fetch #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input logic                   clock,
   input logic                   reset,
   regfile_operand_fetch_if.slave bus
);

   localparam int NREG = 1 << ADDR_W;

   logic [NREG-1:0]   r_pending;
   logic              r_outValid;
   logic [DATA_W-1:0] r_outOp0;
   logic [DATA_W-1:0] r_outOp1;
   logic [ADDR_W-1:0] r_outRd;
   logic              r_outRdEn;

   logic [NREG-1:0]   w_wbHit;
   logic [NREG-1:0]   w_pendEff;
   logic [NREG-1:0]   w_setMask;
   logic [NREG-1:0]   w_pendNext;
   logic              w_hazard;
   logic              w_inReady;
   logic              w_accept;
   logic [DATA_W-1:0] w_op0;
   logic [DATA_W-1:0] w_op1;

   // Register file write port. Writeback passes straight through, except that
   // writes aimed at r0 are suppressed so r0 always reads back as zero.
   assign bus.rf_we = bus.wb_valid & (bus.wb_addr != '0);
   assign bus.rf_wa = bus.wb_addr;
   assign bus.rf_wd = bus.wb_data;

   // Read addresses follow the incoming source fields directly so the
   // register file data arrives in the same cycle as the instruction.
   assign bus.rf_ra0 = bus.in_rs0;
   assign bus.rf_ra1 = bus.in_rs1;

   // One-hot of the register being written back this cycle. A register whose
   // producer is completing right now is no longer a hazard, because its
   // value is available on the bypass path.
   always_comb begin
      w_wbHit = '0;
      if (bus.wb_valid) begin
         w_wbHit[bus.wb_addr] = 1'b1;
      end
      w_pendEff = r_pending & ~w_wbHit;
   end

   // Hazard detection: RAW on either source, plus WAW on the destination so
   // two in-flight producers of one register can never complete out of order.
   // Ready is deliberately independent of in_valid.
   always_comb begin
      w_hazard  = w_pendEff[bus.in_rs0]
                | w_pendEff[bus.in_rs1]
                | (bus.in_rd_en & w_pendEff[bus.in_rd]);
      w_inReady = (~r_outValid | bus.out_ready) & ~w_hazard;
      w_accept  = bus.in_valid & w_inReady;
   end

   assign bus.in_ready = w_inReady;

   // Operand selection for both sources: r0 is forced to zero regardless of
   // what the register file returns, same-cycle writeback data takes priority
   // over the (not yet updated) register file contents.
   always_comb begin
      w_op0 = bus.rf_out0;
      if (bus.in_rs0 == '0) begin
         w_op0 = '0;
      end else if (bus.wb_valid && (bus.wb_addr == bus.in_rs0)) begin
         w_op0 = bus.wb_data;
      end

      w_op1 = bus.rf_out1;
      if (bus.in_rs1 == '0) begin
         w_op1 = '0;
      end else if (bus.wb_valid && (bus.wb_addr == bus.in_rs1)) begin
         w_op1 = bus.wb_data;
      end
   end

   // Next scoreboard value. Writeback clears first and a newly issued
   // producer sets afterwards, so if both hit one register the new producer
   // wins and the register stays pending. Bit 0 is never allowed to set.
   always_comb begin
      w_setMask = '0;
      if (w_accept && bus.in_rd_en && (bus.in_rd != '0)) begin
         w_setMask[bus.in_rd] = 1'b1;
      end
      w_pendNext    = (r_pending & ~w_wbHit) | w_setMask;
      w_pendNext[0] = 1'b0;
   end

   // Scoreboard storage. Reset drops every in-flight producer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= w_pendNext;
      end
   end

   // Execute-side output register. A new instruction loads whenever it is
   // accepted (which already implies the slot is free or draining); with no
   // accept the slot empties once execute takes it, otherwise everything
   // holds stable for the stalled consumer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_outValid <= 1'b0;
         r_outOp0   <= '0;
         r_outOp1   <= '0;
         r_outRd    <= '0;
         r_outRdEn  <= 1'b0;
      end else if (w_accept) begin
         r_outValid <= 1'b1;
         r_outOp0   <= w_op0;
         r_outOp1   <= w_op1;
         r_outRd    <= bus.in_rd;
         r_outRdEn  <= bus.in_rd_en;
      end else if (bus.out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   assign bus.out_valid = r_outValid;
   assign bus.out_op0   = r_outOp0;
   assign bus.out_op1   = r_outOp1;
   assign bus.out_rd    = r_outRd;
   assign bus.out_rd_en = r_outRdEn;

`ifdef OPFETCH_STALL_CNT_EN
   logic [CNT_W-1:0] r_stallCnt;

   // Hazard stall counter. Only cycles where a real instruction is waiting
   // on the scoreboard count; output backpressure is the consumer's problem
   // and is not included. Saturates rather than wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stallCnt <= '0;
      end else if (bus.in_valid && w_hazard && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
   end

   assign bus.stall_cnt = r_stallCnt;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_regfile_operand_fetch
//
// Self-checking bench for regfile_operand_fetch. The bench plays the role of
// decode, execute, writeback and the register file itself. A behavioural
// model (pending flags per register, a register array and one expected output
// slot) predicts every output each cycle. Directed scenarios run first, then
// randomized traffic with a mid-run reset.
// ----------------------------------------------------------------------------
module tb_regfile_operand_fetch;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int NREG   = 1 << ADDR_W;

`ifdef OPFETCH_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic clock;
   logic reset;

   regfile_operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   regfile_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Register file contents owned by the bench; r0 holds junk on purpose so
   // the block has to force zero itself.
   logic [DATA_W-1:0] tbRegs [NREG];

   assign bus.rf_out0 = tbRegs[bus.rf_ra0];
   assign bus.rf_out1 = tbRegs[bus.rf_ra1];

   // Reference model state.
   bit                modelPending [NREG];
   bit                expValid;
   logic [DATA_W-1:0] expOp0;
   logic [DATA_W-1:0] expOp1;
   logic [ADDR_W-1:0] expRd;
   bit                expRdEn;
   int unsigned       expStall;

   int checkCount = 0;
   int errorCount = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                              input logic [DATA_W-1:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
      end
   endtask

   // A source is blocked if an older producer is still outstanding and is not
   // completing in this very cycle.
   function automatic bit isBusy(input int r, input bit wbV, input int wbA);
      return (r != 0) && modelPending[r] && !(wbV && (wbA == r));
   endfunction

   // The value an instruction should see for source register s this cycle.
   function automatic logic [DATA_W-1:0] operandFor(input int s, input bit wbV, input int wbA,
                                                    input logic [DATA_W-1:0] wbD);
      if (s == 0) return '0;
      if (wbV && (wbA == s)) return wbD;
      return tbRegs[s];
   endfunction

   function automatic logic [CNT_W-1:0] expectedStallOut();
      if (!STALL_EN) return '0;
      return CNT_W'(expStall);
   endfunction

   // Drives one cycle of inputs, checks combinational outputs mid-cycle,
   // advances the model across the clock edge and checks registered outputs.
   task automatic applyStimulus(input bit v, input int rs0, input int rs1, input int rd,
                                input bit rdEn, input bit oRdy, input bit wbV, input int wbA,
                                input logic [DATA_W-1:0] wbD, output bit accepted);
      bit hazard;
      bit expReady;
      @(negedge clock);
      bus.in_valid  = v;
      bus.in_rs0    = ADDR_W'(rs0);
      bus.in_rs1    = ADDR_W'(rs1);
      bus.in_rd     = ADDR_W'(rd);
      bus.in_rd_en  = rdEn;
      bus.out_ready = oRdy;
      bus.wb_valid  = wbV;
      bus.wb_addr   = ADDR_W'(wbA);
      bus.wb_data   = wbD;
      #1;

      hazard   = isBusy(rs0, wbV, wbA) || isBusy(rs1, wbV, wbA) || (rdEn && isBusy(rd, wbV, wbA));
      expReady = (!expValid || oRdy) && !hazard;
      accepted = v && expReady;

      checkOutput("in_ready", DATA_W'(bus.in_ready), DATA_W'(expReady));
      checkOutput("rf_we", DATA_W'(bus.rf_we), DATA_W'(wbV && (wbA != 0)));
      checkOutput("rf_ra0", DATA_W'(bus.rf_ra0), DATA_W'(rs0));
      checkOutput("rf_ra1", DATA_W'(bus.rf_ra1), DATA_W'(rs1));
      if (wbV) begin
         checkOutput("rf_wa", DATA_W'(bus.rf_wa), DATA_W'(wbA));
         checkOutput("rf_wd", bus.rf_wd, wbD);
      end

      if (v && hazard && (expStall < (1 << CNT_W) - 1)) expStall++;
      if (accepted) begin
         expValid = 1'b1;
         expOp0   = operandFor(rs0, wbV, wbA, wbD);
         expOp1   = operandFor(rs1, wbV, wbA, wbD);
         expRd    = ADDR_W'(rd);
         expRdEn  = rdEn;
      end else if (oRdy) begin
         expValid = 1'b0;
      end
      if (wbV) modelPending[wbA] = 1'b0;
      if (accepted && rdEn && (rd != 0)) modelPending[rd] = 1'b1;

      @(posedge clock);
      #1;
      if (wbV && (wbA != 0)) tbRegs[wbA] = wbD;

      checkOutput("out_valid", DATA_W'(bus.out_valid), DATA_W'(expValid));
      if (expValid) begin
         checkOutput("out_op0", bus.out_op0, expOp0);
         checkOutput("out_op1", bus.out_op1, expOp1);
         checkOutput("out_rd", DATA_W'(bus.out_rd), DATA_W'(expRd));
         checkOutput("out_rd_en", DATA_W'(bus.out_rd_en), DATA_W'(expRdEn));
      end
      checkOutput("stall_cnt", DATA_W'(bus.stall_cnt), DATA_W'(expectedStallOut()));
   endtask

   // Asserts reset away from any clock edge, checks the cleared outputs while
   // reset is still held, then releases it on a falling edge.
   task automatic applyReset();
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
      checkOutput("rst_out_valid", DATA_W'(bus.out_valid), '0);
      checkOutput("rst_out_op0", bus.out_op0, '0);
      checkOutput("rst_out_op1", bus.out_op1, '0);
      checkOutput("rst_out_rd", DATA_W'(bus.out_rd), '0);
      checkOutput("rst_out_rd_en", DATA_W'(bus.out_rd_en), '0);
      checkOutput("rst_stall_cnt", DATA_W'(bus.stall_cnt), '0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      foreach (modelPending[i]) modelPending[i] = 1'b0;
      expValid = 1'b0;
      expStall = 0;
   endtask

   initial begin
      bit acc;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_rs0    = '0;
      bus.in_rs1    = '0;
      bus.in_rd     = '0;
      bus.in_rd_en  = 1'b0;
      bus.out_ready = 1'b0;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = '0;
      bus.wb_data   = '0;
      for (int i = 0; i < NREG; i++) tbRegs[i] = $urandom;
      tbRegs[0] = 32'hBAD0_0000;
      expValid  = 1'b0;
      expStall  = 0;
      expOp0    = '0;
      expOp1    = '0;
      expRd     = '0;
      expRdEn   = 1'b0;

      applyReset();

      // Writeback to r3 followed by a read of r3 and r0.
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 3, 32'hDEADBEEF, acc);
      applyStimulus(1, 3, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_wb_accept", DATA_W'(acc), 1);
      checkOutput("tp_wb_op0", bus.out_op0, 32'hDEADBEEF);
      checkOutput("tp_wb_op1", bus.out_op1, 32'h0);

      // RAW on r5: stalls until the writeback of r5 arrives, then bypasses.
      applyStimulus(1, 1, 2, 5, 1, 1, 0, 0, 32'h0, acc);
      for (int i = 0; i < 3; i++) applyStimulus(1, 5, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_raw_stall", DATA_W'(acc), 0);
      applyStimulus(1, 5, 0, 0, 0, 1, 1, 5, 32'h12345678, acc);
      checkOutput("tp_raw_accept", DATA_W'(acc), 1);
      checkOutput("tp_raw_op0", bus.out_op0, 32'h12345678);

      // Writes to r0 never reach the register file, r0 always reads zero.
      applyStimulus(0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, acc);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_r0_op0", bus.out_op0, 32'h0);

      // Output backpressure holds the slot for four cycles, then drains.
      applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 32'h0, acc);
      for (int i = 0; i < 4; i++) applyStimulus(1, 3, 4, 0, 0, 0, 0, 0, 32'h0, acc);
      checkOutput("tp_bp_blocked", DATA_W'(acc), 0);
      applyStimulus(1, 3, 4, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_bp_release", DATA_W'(acc), 1);

      // WAW on r7: second producer waits for the first to write back, and r7
      // stays pending afterwards because of the newly issued producer.
      applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 32'h0, acc);
      applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_waw_stall", DATA_W'(acc), 0);
      applyStimulus(1, 0, 0, 7, 1, 1, 1, 7, 32'hA5A5A5A5, acc);
      checkOutput("tp_waw_accept", DATA_W'(acc), 1);
      applyStimulus(1, 7, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_waw_still_pending", DATA_W'(acc), 0);

      // Reset in the middle of a stall on r5 clears the scoreboard.
      applyStimulus(1, 0, 0, 5, 1, 1, 0, 0, 32'h0, acc);
      applyStimulus(1, 5, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      applyStimulus(1, 5, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_rst_pre_stall", DATA_W'(acc), 0);
      applyReset();
      applyStimulus(1, 5, 0, 0, 0, 1, 0, 0, 32'h0, acc);
      checkOutput("tp_rst_post_accept", DATA_W'(acc), 1);

      // Randomized traffic over a small register window to keep hazards common.
      for (int n = 0; n < 2000; n++) begin
         if (n == 1000) applyReset();
         applyStimulus(($urandom_range(0, 9) < 8), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       $urandom_range(0, 1) == 1, ($urandom_range(0, 3) != 0),
                       $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)), $urandom, acc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Initiator/controller that sits in front of the 32x32 register file.
- Accepts decoded instruction fields over a valid/ready handshake and tracks in-flight destination registers in a scoreboard.
- Drives the register file read addresses, forwards same-cycle writeback data, and presents both operands registered to the execute stage.
- Owns the register file write port: writeback passes through it, and register 0 is enforced as hardwired zero.

Parameters:
DATA_W, 32, operand/writeback data width
ADDR_W, 5, register address width (2**ADDR_W registers)
CNT_W, 16, stall counter width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  instruction fields valid
in_ready  output  1  block accepts instruction this cycle
in_rs0  input  ADDR_W  source register 0
in_rs1  input  ADDR_W  source register 1
in_rd  input  ADDR_W  destination register
in_rd_en  input  1  instruction writes in_rd
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts operands
out_op0  output  DATA_W  operand 0
out_op1  output  DATA_W  operand 1
out_rd  output  ADDR_W  registered destination
out_rd_en  output  1  registered destination enable
wb_valid  input  1  writeback this cycle
wb_addr  input  ADDR_W  writeback register
wb_data  input  DATA_W  writeback data
rf_ra0  output  ADDR_W  register file read address 0 (= in_rs0, combinational)
rf_ra1  output  ADDR_W  register file read address 1 (= in_rs1, combinational)
rf_out0  input  DATA_W  register file read data 0
rf_out1  input  DATA_W  register file read data 1
rf_we  output  1  register file write enable
rf_wa  output  ADDR_W  register file write address
rf_wd  output  DATA_W  register file write data
stall_cnt  output  CNT_W  hazard stall cycles

Behaviour:
- Reset (reset low, async):
  - pending[] = 0, out_valid = 0, out_op0/out_op1/out_rd/out_rd_en = 0, stall_cnt = 0.
  - Reset mid-transaction discards the held operands and all pending bits.
- Write port (combinational):
  - rf_we = wb_valid & (wb_addr != 0); rf_wa = wb_addr; rf_wd = wb_data.
  - Writes to r0 never reach the register file.
- Scoreboard: pending[2**ADDR_W] bits; pending[0] is constant 0.
- Hazard (combinational):
  - pend_eff[r] = pending[r] & ~(wb_valid & wb_addr==r).
  - hazard = pend_eff[in_rs0] | pend_eff[in_rs1] | (in_rd_en & pend_eff[in_rd]). The last term is the WAW check.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard.
  - Accept = in_valid & in_ready.
  - in_ready does not depend on in_valid; it does depend on in_rs0/in_rs1/in_rd.
- Operand select, per source s:
  - s == 0 gives 0.
  - Else, if wb_valid & wb_addr == s, gives wb_data (bypass).
  - Else gives rf_outN.
- On accept:
  - Selected operands, in_rd and in_rd_en are registered into the out_* outputs.
  - out_valid = 1 next cycle. Latency is 1 cycle, input to output.
- Without accept: if out_ready, out_valid clears; otherwise out_* hold stable.
- Pending update at each edge:
  - Clear pending[wb_addr] if wb_valid.
  - Then set pending[in_rd] if accept & in_rd_en & in_rd != 0.
  - Set wins on the same register, because a new producer was issued.
- Writeback to a non-pending register: writes the register file; scoreboard unchanged.
- stall_cnt: increments (saturating at all-ones) every cycle with in_valid & hazard. Output-backpressure stalls are not counted.

Optional Feature:
- Macro OPFETCH_STALL_CNT_EN.
- Defined: stall_cnt counter implemented as above.
- Undefined: no counter flops; stall_cnt tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then wb_valid=1, wb_addr=3, wb_data=0xDEADBEEF; next cycle issue rs0=3, rs1=0 -> out_op0=0xDEADBEEF, out_op1=0, out_valid high one cycle after accept.
- Issue rd=5, rd_en=1, then issue rs0=5 -> in_ready=0 and stall_cnt increments each cycle; wb_valid with wb_addr=5, wb_data=0x12345678 in the same cycle as in_valid -> accept that cycle, out_op0=0x12345678.
- wb_valid, wb_addr=0, wb_data=0xFFFFFFFF -> rf_we=0; later read of rs0=0 -> out_op0=0.
- Hold out_ready=0 with out_valid=1 -> in_ready=0, out_* stable for 4 cycles; raise out_ready -> next instruction accepted the same cycle.
- WAW: issue rd=7, then issue rd=7 again -> stalled until wb_addr=7 arrives; accepted that cycle, pending[7] remains set.
- Assert reset mid-stall with pending[5]=1 -> out_valid=0, stall_cnt=0; after release, issue rs0=5 -> accepted immediately.
